// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: push/pop FIFO controller wrapped around an external
// single-port-pair RAM (registered read, one cycle latency).
// Owns the read/write pointers and the occupancy count; storage lives in the RAM.
// Optional feature macro: RAM_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// outputs that flag dropped pushes (while full) and dropped pops (while empty).
//
// Handshake: push is taken on a clock edge when full=0 and rst=0; pop is taken
// when empty=0 and rst=0. Both decisions use the registered flags, so a pop in
// the same cycle never frees a slot for a push. Each accepted pop is answered
// by pop_valid=1 exactly one cycle later, with pop_data carrying the word.
module ram_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  full,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  pop_valid,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  ram_wr_enb,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic                  ram_rd_enb,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data
`ifdef RAM_FIFO_ERR_FLAGS_EN
   ,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = '0;
   localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count_q;
   logic [ADDR_WIDTH:0]   count_nxt;
   logic                  empty_q;
   logic                  full_q;
   logic                  pop_valid_q;
   logic                  push_acc;
   logic                  pop_acc;

   // Accept decisions from registered flags; reset blocks all RAM traffic.
   always_comb begin
      push_acc = push & ~full_q & ~rst;
      pop_acc  = pop & ~empty_q & ~rst;
   end

   // Next occupancy: a simultaneous push and pop leaves the count unchanged.
   always_comb begin
      count_nxt = count_q;
      case ({push_acc, pop_acc})
         2'b10:   count_nxt = count_q + CNT_ONE;
         2'b01:   count_nxt = count_q - CNT_ONE;
         default: count_nxt = count_q;
      endcase
   end

   // Pointers, occupancy, flags and the read-valid strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         pop_valid_q <= 1'b0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
         count_q     <= count_nxt;
         empty_q     <= (count_nxt == CNT_ZERO);
         full_q      <= (count_nxt == CNT_DEPTH);
         pop_valid_q <= pop_acc;
      end
   end

`ifdef RAM_FIFO_ERR_FLAGS_EN
   // Sticky records of dropped requests; only reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= overflow  | (push & full_q);
         underflow <= underflow | (pop & empty_q);
      end
   end
`endif

   // RAM port drive and consumer-facing outputs.
   always_comb begin
      ram_wr_enb  = push_acc;
      ram_wr_addr = wr_ptr;
      ram_wr_data = push_data;
      ram_rd_enb  = pop_acc;
      ram_rd_addr = rd_ptr;
      pop_data    = ram_rd_data;
      pop_valid   = pop_valid_q;
      count       = count_q;
      empty       = empty_q;
      full        = full_q;
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl: behavioural RAM, queue-based reference model,
// scoreboard monitor for pop data. Macro RAM_FIFO_ERR_FLAGS_EN enables flag checks.
module tb_ram_fifo_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          push = 1'b0;
   logic [DW-1:0] push_data = '0;
   logic          pop = 1'b0;
   logic          full, empty, pop_valid;
   logic [DW-1:0] pop_data;
   logic [AW:0]   count;
   logic          ram_wr_enb, ram_rd_enb;
   logic [AW-1:0] ram_wr_addr, ram_rd_addr;
   logic [DW-1:0] ram_wr_data;
   logic [DW-1:0] ram_rd_data = '0;
`ifdef RAM_FIFO_ERR_FLAGS_EN
   logic          overflow, underflow;
`endif

   int total = 0;
   int bad   = 0;

   // reference model
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] exp_q[$];
   int            m_wr = 0;
   int            m_rd = 0;
   bit            m_ovf = 0;
   bit            m_unf = 0;
   bit            inited = 0;

   // clock / reset block
   always #5 clk = ~clk;

   ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .push(push), .push_data(push_data), .full(full),
      .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .empty(empty),
      .count(count), .ram_wr_enb(ram_wr_enb), .ram_wr_addr(ram_wr_addr),
      .ram_wr_data(ram_wr_data), .ram_rd_enb(ram_rd_enb),
      .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
`ifdef RAM_FIFO_ERR_FLAGS_EN
      , .overflow(overflow), .underflow(underflow)
`endif
   );

   // behavioural RAM with registered read
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ram_wr_enb) mem[ram_wr_addr] <= ram_wr_data;
      if (ram_rd_enb) ram_rd_data <= mem[ram_rd_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every pop_valid must match the oldest expected word
   always @(posedge clk) begin
      #1;
      if (pop_valid === 1'b1) begin
         if (exp_q.size() == 0) chk("spurious_pop_valid", 1, 0);
         else chk("pop_data", {24'd0, pop_data}, {24'd0, exp_q.pop_front()});
      end else if (exp_q.size() != 0) begin
         chk("missing_pop_valid", 0, 1);
         void'(exp_q.pop_front());
      end
   end

   // driver: one clock cycle of stimulus, checked against the model
   task automatic step(input bit p, input logic [DW-1:0] d, input bit q, input bit r);
      bit acc_push, acc_pop;
      int sz;
      @(negedge clk);
      push = p; push_data = d; pop = q; rst = r;
      #1;
      sz = model_q.size();
      acc_push = p && !r && (sz < DEPTH);
      acc_pop  = q && !r && (sz > 0);
      if (inited) begin
         chk("count", {27'd0, count}, sz);
         chk("empty", {31'd0, empty}, (sz == 0));
         chk("full",  {31'd0, full},  (sz == DEPTH));
`ifdef RAM_FIFO_ERR_FLAGS_EN
         chk("overflow",  {31'd0, overflow},  m_ovf);
         chk("underflow", {31'd0, underflow}, m_unf);
`endif
      end
      chk("ram_wr_enb", {31'd0, ram_wr_enb}, acc_push);
      chk("ram_rd_enb", {31'd0, ram_rd_enb}, acc_pop);
      if (acc_push) begin
         chk("ram_wr_addr", {28'd0, ram_wr_addr}, m_wr);
         chk("ram_wr_data", {24'd0, ram_wr_data}, {24'd0, d});
      end
      if (acc_pop) chk("ram_rd_addr", {28'd0, ram_rd_addr}, m_rd);
      if (r) begin
         model_q.delete();
         m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0;
         inited = 1;
      end else begin
         if (p && sz == DEPTH) m_ovf = 1;
         if (q && sz == 0)     m_unf = 1;
         if (acc_pop) begin
            exp_q.push_back(model_q.pop_front());
            m_rd = (m_rd + 1) % DEPTH;
         end
         if (acc_push) begin
            model_q.push_back(d);
            m_wr = (m_wr + 1) % DEPTH;
         end
      end
   endtask

   task automatic idle();
      step(0, '0, 0, 0);
   endtask

   task automatic drain();
      while (model_q.size() > 0) step(0, '0, 1, 0);
   endtask

   initial begin
      // reset with push held high
      step(1, 8'd23, 0, 1);
      step(1, 8'd23, 0, 1);
      idle();

      // fill 1..16, overflow attempt, drain, underflow attempt
      for (int i = 1; i <= DEPTH; i++) step(1, DW'(i), 0, 0);
      idle();
      step(1, 8'hAA, 0, 0);
      idle();
      drain();
      idle();
      step(0, '0, 1, 0);
      idle();

      // wrap-around
      for (int i = 0; i < 10; i++) step(1, DW'($urandom_range(0, 255)), 0, 0);
      for (int i = 0; i < 10; i++) step(0, '0, 1, 0);
      for (int i = 0; i < 10; i++) step(1, DW'(8'h30 + i), 0, 0);
      drain();
      idle();

      // simultaneous traffic at count 5, then full and empty boundaries
      for (int i = 0; i < 5; i++) step(1, DW'($urandom_range(0, 255)), 0, 0);
      for (int i = 0; i < 20; i++) step(1, DW'($urandom_range(0, 255)), 1, 0);
      while (model_q.size() < DEPTH) step(1, DW'($urandom_range(0, 255)), 0, 0);
      step(1, 8'h55, 1, 0);
      idle();
      drain();
      step(1, 8'h66, 1, 0);
      idle();
      drain();

      // reset mid-stream with a pop in the reset cycle
      for (int i = 0; i < 7; i++) step(1, DW'($urandom_range(0, 255)), 0, 0);
      step(0, '0, 1, 1);
      idle();
      step(1, 8'h77, 0, 0);
      step(0, '0, 1, 0);
      idle();

      // random traffic with occasional resets
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 99) < 55), DW'($urandom_range(0, 255)),
              ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 2));
      drain();
      idle();
      idle();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
